// File: rtl/serial_borrow_subtractor.sv
// serial_borrow_subtractor
// Bit-serial ripple-borrow subtractor: Diff = a - b - bin, one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flip-flop.
// A start/done handshake lets a controller issue operations and collect results.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; Diff/B_Out hold the last result
//   RUN     | one operand bit per cycle through the subtractor cell
//   DONE    | one-cycle done pulse; start here begins the next operation
module serial_borrow_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] Diff,
    output logic             B_Out,
    output logic             busy,
    output logic             done
);

    // The counter carries one bit more than strictly needed so it cannot wrap
    // while indexing the last bit.
    localparam int              CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             br;

    logic             accept;
    logic             last_bit;
    logic             a_i;
    logic             b_i;
    logic             d_bit;
    logic             br_nxt;

    // Full-subtractor cell on the current LSB of the operand shift registers.
    always_comb begin
        a_i     = a_sh[0];
        b_i     = b_sh[0];
        d_bit   = a_i ^ b_i ^ br;
        br_nxt  = (~a_i & b_i) | (~(a_i ^ b_i) & br);
        res_nxt = {d_bit, res_sh[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; start is only honoured in IDLE or DONE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt == LAST_BIT) begin
                    last_bit  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture on acceptance, then shift one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            br     <= bin;
            cnt    <= '0;
        end else if (state == ST_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nxt;
            br     <= br_nxt;
            cnt    <= cnt + CW'(1);
        end
    end

    // Result registers load only on the last RUN edge and otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            Diff  <= '0;
            B_Out <= 1'b0;
        end else if (last_bit) begin
            Diff  <= res_nxt;
            B_Out <= br_nxt;
        end
    end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Bench for serial_borrow_subtractor at WIDTH=8 and WIDTH=13, checked every
// cycle against an operation-level model plus literal directed results.
module tb_serial_borrow_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        bin8 = 1'b0;
    logic [7:0]  diff8;
    logic        bout8;
    logic        busy8;
    logic        done8;

    logic        start13 = 1'b0;
    logic [12:0] a13 = '0;
    logic [12:0] b13 = '0;
    logic        bin13 = 1'b0;
    logic [12:0] diff13;
    logic        bout13;
    logic        busy13;
    logic        done13;

    serial_borrow_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .Diff(diff8), .B_Out(bout8), .busy(busy8), .done(done8)
    );

    serial_borrow_subtractor #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .bin(bin13),
        .Diff(diff13), .B_Out(bout13), .busy(busy13), .done(done13)
    );

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {borrow, diff} as a (w+1)-bit value of {0,a} - b - bin.
    function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b,
                                             input logic bin, input int w);
        logic [31:0] r;
        r = a - b - {31'b0, bin};
        return r & ((32'd1 << (w + 1)) - 32'd1);
    endfunction

    // Operation-level model: an accepted request is busy for WIDTH cycles,
    // then the result appears with a one-cycle done.
    int          m8_left = 0;
    logic        m8_done = 1'b0;
    logic [7:0]  m8_diff = '0;
    logic        m8_bout = 1'b0;
    logic [8:0]  m8_pend = '0;

    int          m13_left = 0;
    logic        m13_done = 1'b0;
    logic [12:0] m13_diff = '0;
    logic        m13_bout = 1'b0;
    logic [13:0] m13_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m8_left = 0; m8_done = 1'b0; m8_diff = '0; m8_bout = 1'b0;
        end else if (m8_left > 0) begin
            m8_left--;
            if (m8_left == 0) begin
                m8_done = 1'b1;
                {m8_bout, m8_diff} = m8_pend;
            end
        end else begin
            m8_done = 1'b0;
            if (start8) begin
                m8_pend = ref_sub({24'b0, a8}, {24'b0, b8}, bin8, 8) & 32'h1FF;
                m8_left = 8;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m13_left = 0; m13_done = 1'b0; m13_diff = '0; m13_bout = 1'b0;
        end else if (m13_left > 0) begin
            m13_left--;
            if (m13_left == 0) begin
                m13_done = 1'b1;
                {m13_bout, m13_diff} = m13_pend;
            end
        end else begin
            m13_done = 1'b0;
            if (start13) begin
                m13_pend = 14'(ref_sub({19'b0, a13}, {19'b0, b13}, bin13, 13));
                m13_left = 13;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy8", busy8, m8_left > 0);
            chk("done8", done8, m8_done);
            chk("diff8", diff8, m8_diff);
            chk("bout8", bout8, m8_bout);
            chk("excl8", busy8 & done8, 0);
            chk("busy13", busy13, m13_left > 0);
            chk("done13", done13, m13_done);
            chk("diff13", diff13, m13_diff);
            chk("bout13", bout13, m13_bout);
            chk("excl13", busy13 & done13, 0);
        end
    end

    // Called at the negedge just after the accepting edge. Counts edges until
    // done; pokes start (with junk operands) at the given RUN cycles.
    task automatic wait_done8(input int poke1, input int poke2, input bit hold,
                              output int edges, output int busy_cnt, output bit ok);
        edges = 0; busy_cnt = 0; ok = 1'b0;
        while (edges < 40) begin
            if (done8) begin ok = 1'b1; break; end
            if (busy8) busy_cnt++;
            start8 = hold || edges == poke1 || edges == poke2;
            if (!hold && start8) begin
                a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            end
            @(negedge clk);
            edges++;
        end
        start8 = hold;
    endtask

    task automatic wait_done13(input int poke1, output int edges, output int busy_cnt, output bit ok);
        edges = 0; busy_cnt = 0; ok = 1'b0;
        while (edges < 60) begin
            if (done13) begin ok = 1'b1; break; end
            if (busy13) busy_cnt++;
            start13 = (edges == poke1);
            if (start13) begin
                a13 = 13'($urandom); b13 = 13'($urandom); bin13 = 1'($urandom);
            end
            @(negedge clk);
            edges++;
        end
        start13 = 1'b0;
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                           input logic [8:0] exp, input int poke1, input int poke2);
        int edges, bc;
        bit ok;
        start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        @(negedge clk);
        wait_done8(poke1, poke2, 1'b0, edges, bc, ok);
        chk("done_seen8", ok, 1);
        chk("latency8", edges, 8);
        chk("busy_len8", bc, 8);
        chk("result_diff8", diff8, exp[7:0]);
        chk("result_bout8", bout8, exp[8]);
    endtask

    task automatic run_op13(input logic [12:0] a, input logic [12:0] b, input logic bin, input int poke1);
        int edges, bc;
        bit ok;
        logic [31:0] exp;
        exp = ref_sub({19'b0, a}, {19'b0, b}, bin, 13);
        start13 = 1'b1; a13 = a; b13 = b; bin13 = bin;
        @(negedge clk);
        wait_done13(poke1, edges, bc, ok);
        chk("done_seen13", ok, 1);
        chk("latency13", edges, 13);
        chk("busy_len13", bc, 13);
        chk("result_diff13", diff13, exp[12:0]);
        chk("result_bout13", bout13, exp[13]);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges, bc;
        bit ok;
        logic [7:0] ra, rb;
        logic rbin;
        logic [31:0] e;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_diff8", diff8, 0);
        chk("rst_bout8", bout8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_diff13", diff13, 0);
        chk("rst_busy13", busy13, 0);
        chk_on = 1'b1;

        run_op8(8'h50, 8'h20, 1'b0, 9'h030, -1, -1);
        run_op8(8'h00, 8'h01, 1'b0, 9'h1FF, -1, -1);
        run_op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, -1, -1);
        run_op8(8'h80, 8'h7F, 1'b1, 9'h000, -1, -1);

        // Start pulses during RUN must be ignored.
        run_op8(8'h10, 8'h01, 1'b0, 9'h00F, 3, 7);
        @(negedge clk);
        chk("no_second_busy", busy8, 0);
        chk("no_second_done", done8, 0);

        // Reset in RUN cycle 4 aborts with no done and clears the result.
        start8 = 1'b1; a8 = 8'h50; b8 = 8'h20; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_diff", diff8, 0);
        chk("abort_bout", bout8, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_done", done8, 0);
        end
        run_op8(8'h05, 8'h03, 1'b0, 9'h002, -1, -1);

        // Back-to-back with start held high.
        start8 = 1'b1; a8 = 8'h09; b8 = 8'h04; bin8 = 1'b0;
        @(negedge clk);
        a8 = 8'h02; b8 = 8'h03;
        wait_done8(-1, -1, 1'b1, edges, bc, ok);
        chk("b2b_first_seen", ok, 1);
        chk("b2b_first_lat", edges, 8);
        chk("b2b_first_diff", diff8, 8'h05);
        chk("b2b_first_bout", bout8, 0);
        @(negedge clk);
        chk("b2b_rebusy", busy8, 1);
        chk("b2b_hold_diff", diff8, 8'h05);
        wait_done8(-1, -1, 1'b1, edges, bc, ok);
        start8 = 1'b0;
        chk("b2b_second_seen", ok, 1);
        chk("b2b_spacing", edges + 1, 9);
        chk("b2b_second_diff", diff8, 8'hFF);
        chk("b2b_second_bout", bout8, 1);

        // Randomized regression, WIDTH=8.
        for (int n = 0; n < 1200; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            e = ref_sub({24'b0, ra}, {24'b0, rb}, rbin, 8);
            run_op8(ra, rb, rbin, e[8:0],
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Randomized regression, WIDTH=13.
        for (int n = 0; n < 1200; n++) begin
            run_op13(13'($urandom), 13'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
